fpga_test_runner: RTL and testbench

- Sequencer for the generated `fpga` test programs: owns each program's `reset`, runs programs one at a time, waits for `finished`, samples `success`, and aggregates results.
- Sits between the board top level and up to NTests program instances.
- Instances are multiplexed externally by `testSelect`; `finished`/`success` return through a shared mux.
- Adds a per-test watchdog so a hung program cannot stall the run.

---
 rtl/fpga_test_runner.sv | 202 ++++++++++++++++++++
 tb/tb_fpga_test_runner.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpga_test_runner.sv
// fpga_test_runner
//   Sequences up to NTests generated test programs one at a time. Each
//   program is held in reset for ResetCycles clocks, released, and watched
//   until it raises finished or the watchdog expires. Results are gathered
//   into per-test pass/timeout masks and a saturating failure count.
//
// Ports
//   clock         rising-edge clock
//   reset         asynchronous active-low reset
//   start         one-cycle run request, honoured only when idle or done
//   testSelect    index of the program currently driven and observed
//   testReset     active-high reset to the selected program
//   testFinished  finished flag of the selected program
//   testSuccess   success flag of the selected program
//   busy          run in progress
//   done          run complete, results valid
//   allPassed     every test ran and passed (valid while done)
//   passMask      bit i set when test i passed
//   timeoutMask   bit i set when test i hit the watchdog
//   failCount     number of failed or timed-out tests (saturating)
//
// Build option
//   FPGA_TEST_RUNNER_STOP_ON_FAIL_EN: end the run at the first failure or
//   timeout; testSelect then keeps the failing index.
module fpga_test_runner #(
  parameter int unsigned NTests      = 4,
  parameter int unsigned SelWidth    = 8,
  parameter int unsigned ResetCycles = 2,
  parameter int unsigned Timeout     = 4096,
  parameter int unsigned TimerWidth  = 16
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  output logic [SelWidth-1:0] testSelect,
  output logic                testReset,
  input  logic                testFinished,
  input  logic                testSuccess,
  output logic                busy,
  output logic                done,
  output logic                allPassed,
  output logic [NTests-1:0]   passMask,
  output logic [NTests-1:0]   timeoutMask,
  output logic [SelWidth:0]   failCount
);

  localparam int unsigned RcWidth = (ResetCycles > 1) ? $clog2(ResetCycles) : 1;

  localparam logic [SelWidth-1:0]   LastSel   = SelWidth'(NTests - 1);
  localparam logic [TimerWidth-1:0] TimerLast = TimerWidth'(Timeout - 1);
  localparam logic [RcWidth-1:0]    RstLast   = RcWidth'(ResetCycles - 1);

`ifdef FPGA_TEST_RUNNER_STOP_ON_FAIL_EN
  localparam bit StopOnFail = 1'b1;
`else
  localparam bit StopOnFail = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_RESET,
    S_RUN,
    S_RECORD,
    S_DONE
  } state_e;

  state_e                state_q,        state_d;
  logic [SelWidth-1:0]   test_select_q,  test_select_d;
  logic [RcWidth-1:0]    rst_cnt_q,      rst_cnt_d;
  logic [TimerWidth-1:0] timer_q,        timer_d;
  logic                  pass_q,         pass_d;
  logic                  hit_timeout_q,  hit_timeout_d;
  logic [NTests-1:0]     pass_mask_q,    pass_mask_d;
  logic [NTests-1:0]     timeout_mask_q, timeout_mask_d;
  logic [SelWidth:0]     fail_count_q,   fail_count_d;
  logic                  all_passed_q,   all_passed_d;

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q        <= S_IDLE;
      test_select_q  <= '0;
      rst_cnt_q      <= '0;
      timer_q        <= '0;
      pass_q         <= 1'b0;
      hit_timeout_q  <= 1'b0;
      pass_mask_q    <= '0;
      timeout_mask_q <= '0;
      fail_count_q   <= '0;
      all_passed_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      test_select_q  <= test_select_d;
      rst_cnt_q      <= rst_cnt_d;
      timer_q        <= timer_d;
      pass_q         <= pass_d;
      hit_timeout_q  <= hit_timeout_d;
      pass_mask_q    <= pass_mask_d;
      timeout_mask_q <= timeout_mask_d;
      fail_count_q   <= fail_count_d;
      all_passed_q   <= all_passed_d;
    end
  end

  // Next-state and datapath
  always_comb begin
    state_d        = state_q;
    test_select_d  = test_select_q;
    rst_cnt_d      = rst_cnt_q;
    timer_d        = timer_q;
    pass_d         = pass_q;
    hit_timeout_d  = hit_timeout_q;
    pass_mask_d    = pass_mask_q;
    timeout_mask_d = timeout_mask_q;
    fail_count_d   = fail_count_q;
    all_passed_d   = all_passed_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d        = S_RESET;
          test_select_d  = '0;
          rst_cnt_d      = '0;
          pass_mask_d    = '0;
          timeout_mask_d = '0;
          fail_count_d   = '0;
          all_passed_d   = 1'b0;
        end
      end

      S_RESET: begin
        if (rst_cnt_q == RstLast) begin
          state_d = S_RUN;
          timer_d = '0;
        end else begin
          rst_cnt_d = rst_cnt_q + 1'b1;
        end
      end

      S_RUN: begin
        // finished takes priority over the watchdog on the same clock
        if (testFinished) begin
          state_d       = S_RECORD;
          pass_d        = testSuccess;
          hit_timeout_d = 1'b0;
        end else if (timer_q == TimerLast) begin
          state_d       = S_RECORD;
          pass_d        = 1'b0;
          hit_timeout_d = 1'b1;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end

      S_RECORD: begin
        for (int unsigned i = 0; i < NTests; i++) begin
          if (test_select_q == SelWidth'(i)) begin
            pass_mask_d[i]    = pass_q;
            timeout_mask_d[i] = hit_timeout_q;
          end
        end
        if (!pass_q && (fail_count_q != '1)) begin
          fail_count_d = fail_count_q + 1'b1;
        end
        if ((test_select_q == LastSel) || (StopOnFail && !pass_q)) begin
          state_d      = S_DONE;
          // uses the count including this test's result
          all_passed_d = (fail_count_d == '0);
        end else begin
          state_d       = S_RESET;
          test_select_d = test_select_q + 1'b1;
          rst_cnt_d     = '0;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    testReset = 1'b1;
    busy      = 1'b0;
    done      = 1'b0;
    case (state_q)
      S_RESET, S_RECORD: busy = 1'b1;
      S_RUN: begin
        busy      = 1'b1;
        testReset = 1'b0;
      end
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  assign testSelect  = test_select_q;
  assign allPassed   = all_passed_q;
  assign passMask    = pass_mask_q;
  assign timeoutMask = timeout_mask_q;
  assign failCount   = fail_count_q;

endmodule

// File: tb/tb_fpga_test_runner.sv
// Bench for fpga_test_runner: a program model answers on testFinished /
// testSuccess from a per-test profile (finish clock, success bit); each run
// is checked against expected results, from a table or from a reference
// model computed directly from the per-test latency/result rules.
module tb_fpga_test_runner;

  localparam int NT = 4;
  localparam int RC = 2;
  localparam int TO = 10;
  localparam int SW = 8;

`ifdef FPGA_TEST_RUNNER_STOP_ON_FAIL_EN
  localparam bit STOP = 1'b1;
`else
  localparam bit STOP = 1'b0;
`endif

  typedef int unsigned u32_t;

  // fin[i]: RUN clock (1-based) on which test i raises finished; 0 = never
  typedef struct {
    logic [NT-1:0][7:0] fin;
    logic [NT-1:0]      suc;
    int                 inject;
    u32_t               e_isel;
    u32_t               e_pass;
    u32_t               e_tmo;
    u32_t               e_fail;
    u32_t               e_all;
    u32_t               e_sel;
    u32_t               e_cyc;
    u32_t               e_ran;
  } vec_t;

  logic          clock;
  logic          rst_n;
  logic          start;
  logic [SW-1:0] testSelect;
  logic          testReset;
  logic          testFinished;
  logic          testSuccess;
  logic          busy;
  logic          done;
  logic          allPassed;
  logic [NT-1:0] passMask;
  logic [NT-1:0] timeoutMask;
  logic [SW:0]   failCount;

  int   prof_fin [NT];
  logic prof_suc [NT];
  u32_t total;
  u32_t bad;
  vec_t tbl [9];

  fpga_test_runner #(
    .NTests      (NT),
    .SelWidth    (SW),
    .ResetCycles (RC),
    .Timeout     (TO),
    .TimerWidth  (16)
  ) dut (
    .clock        (clock),
    .reset        (rst_n),
    .start        (start),
    .testSelect   (testSelect),
    .testReset    (testReset),
    .testFinished (testFinished),
    .testSuccess  (testSuccess),
    .busy         (busy),
    .done         (done),
    .allPassed    (allPassed),
    .passMask     (passMask),
    .timeoutMask  (timeoutMask),
    .failCount    (failCount)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Program model: counts RUN clocks of the selected program; noise while held in reset
  initial begin : prog_model
    int run_cnt;
    int sel;
    run_cnt      = 0;
    testFinished = 1'b0;
    testSuccess  = 1'b0;
    forever begin
      @(negedge clock);
      sel = int'(testSelect);
      if (testReset) begin
        run_cnt      = 0;
        testFinished = 1'($urandom);
        testSuccess  = 1'($urandom);
      end else begin
        run_cnt++;
        if (sel < NT && prof_fin[sel] == run_cnt) begin
          testFinished = 1'b1;
          testSuccess  = prof_suc[sel];
        end else begin
          testFinished = 1'b0;
          testSuccess  = 1'($urandom);
        end
      end
    end
  end

  task automatic chk(input string nm, input u32_t act, input u32_t exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input int f0, input int f1, input int f2, input int f3,
                              input logic [NT-1:0] s, input int inj,
                              input int p, input int t, input int f, input int a,
                              input int sel, input int cyc, input int ran);
    vec_t v;
    v.fin[0] = 8'(f0);
    v.fin[1] = 8'(f1);
    v.fin[2] = 8'(f2);
    v.fin[3] = 8'(f3);
    v.suc    = s;
    v.inject = inj;
    v.e_isel = 0;
    v.e_pass = u32_t'(p);
    v.e_tmo  = u32_t'(t);
    v.e_fail = u32_t'(f);
    v.e_all  = u32_t'(a);
    v.e_sel  = u32_t'(sel);
    v.e_cyc  = u32_t'(cyc);
    v.e_ran  = u32_t'(ran);
    return v;
  endfunction

  // Reference: each run test costs RC + run length + 1; run length is the
  // finish clock if it falls inside the watchdog window, else TO.
  function automatic vec_t model(input vec_t v);
    vec_t r;
    u32_t fails;
    bit   in_time;
    bit   ok;
    int   fv;
    r        = v;
    fails    = 0;
    r.e_pass = 0;
    r.e_tmo  = 0;
    r.e_cyc  = 0;
    r.e_ran  = 0;
    r.e_sel  = 0;
    r.e_isel = 0;
    for (int i = 0; i < NT; i++) begin
      fv      = int'(v.fin[i]);
      in_time = (fv >= 1) && (fv <= TO);
      ok      = in_time && v.suc[i];
      r.e_cyc += u32_t'(RC + (in_time ? fv : TO) + 1);
      if (ok) r.e_pass |= u32_t'(1) << i;
      else    fails++;
      if (!in_time) r.e_tmo |= u32_t'(1) << i;
      r.e_ran++;
      r.e_sel = u32_t'(i);
      if (STOP && !ok) break;
    end
    r.e_fail = fails;
    r.e_all  = (fails == 0) ? 1 : 0;
    return r;
  endfunction

  task automatic load(input vec_t v);
    for (int i = 0; i < NT; i++) begin
      prof_fin[i] = int'(v.fin[i]);
      prof_suc[i] = v.suc[i];
    end
  endtask

  // Leaves time at 1 unit after the start edge
  task automatic pulse_start();
    @(posedge clock);
    #1 start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
  endtask

  task automatic run_check(input vec_t v, input string nm);
    u32_t cycles;
    u32_t rst_hi;
    u32_t sel_bad;
    load(v);
    pulse_start();
    chk({nm, ".start_busy"}, u32_t'(busy), 1);
    chk({nm, ".start_done"}, u32_t'(done), 0);
    chk({nm, ".start_sel"},  u32_t'(testSelect), 0);
    chk({nm, ".start_clr"},  u32_t'(passMask) + u32_t'(timeoutMask) + u32_t'(failCount) + u32_t'(allPassed), 0);
    cycles  = 0;
    rst_hi  = 0;
    sel_bad = 0;
    while (!done && cycles < 500) begin
      if (testReset) rst_hi++;
      if (u32_t'(testSelect) >= NT) sel_bad++;
      if (v.inject >= 0 && cycles == u32_t'(v.inject)) start = 1'b1;
      @(posedge clock);
      #1;
      cycles++;
      if (v.inject >= 0 && cycles == u32_t'(v.inject) + 1) begin
        start = 1'b0;
        chk({nm, ".inj_sel"},  u32_t'(testSelect), v.e_isel);
        chk({nm, ".inj_busy"}, u32_t'(busy), 1);
      end
    end
    chk({nm, ".cycles"},    cycles, v.e_cyc);
    chk({nm, ".done"},      u32_t'(done), 1);
    chk({nm, ".busy"},      u32_t'(busy), 0);
    chk({nm, ".testReset"}, u32_t'(testReset), 1);
    chk({nm, ".passMask"},  u32_t'(passMask), v.e_pass);
    chk({nm, ".tmoMask"},   u32_t'(timeoutMask), v.e_tmo);
    chk({nm, ".failCount"}, u32_t'(failCount), v.e_fail);
    chk({nm, ".allPassed"}, u32_t'(allPassed), v.e_all);
    chk({nm, ".sel"},       u32_t'(testSelect), v.e_sel);
    chk({nm, ".rst_hi"},    rst_hi, v.e_ran * u32_t'(RC + 1));
    chk({nm, ".sel_range"}, sel_bad, 0);
    @(posedge clock);
    #1;
    chk({nm, ".hold_done"}, u32_t'(done), 1);
    chk({nm, ".hold_pass"}, u32_t'(passMask), v.e_pass);
  endtask

  initial begin : main
    vec_t v;
    int   n;
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    start = 1'b0;
    for (int i = 0; i < NT; i++) begin
      prof_fin[i] = 0;
      prof_suc[i] = 1'b0;
    end

    //            f0  f1  f2  f3  suc      inj pass            tmo             fail          all sel           cyc             ran
    tbl[0] = mk(3,  3,  3,  3,  4'b1111, -1, 15,             0,              0,            1,  3,            24,             4);
    tbl[1] = mk(3,  3,  3,  3,  4'b1011, -1, STOP ? 3 : 11,  0,              1,            0,  STOP ? 2 : 3, STOP ? 18 : 24, STOP ? 3 : 4);
    tbl[2] = mk(3,  0,  3,  3,  4'b1111, -1, STOP ? 1 : 13,  2,              1,            0,  STOP ? 1 : 3, STOP ? 19 : 31, STOP ? 2 : 4);
    tbl[3] = mk(3,  10, 3,  3,  4'b1111, -1, 15,             0,              0,            1,  3,            31,             4);
    tbl[4] = mk(1,  1,  1,  1,  4'b1111, -1, 15,             0,              0,            1,  3,            16,             4);
    tbl[5] = mk(3,  3,  3,  10, 4'b0111, -1, 7,              0,              1,            0,  3,            31,             4);
    tbl[6] = mk(3,  3,  3,  3,  4'b1111, 8,  15,             0,              0,            1,  3,            24,             4);
    tbl[7] = mk(0,  0,  0,  0,  4'b1111, -1, 0,              STOP ? 1 : 15,  STOP ? 1 : 4, 0,  STOP ? 0 : 3, STOP ? 13 : 52, STOP ? 1 : 4);
    tbl[8] = mk(11, 3,  3,  3,  4'b1111, -1, STOP ? 0 : 14,  1,              1,            0,  STOP ? 0 : 3, STOP ? 13 : 31, STOP ? 1 : 4);
    tbl[6].e_isel = 1;

    #1;
    chk("rst.testReset", u32_t'(testReset), 1);
    chk("rst.busy",      u32_t'(busy), 0);
    chk("rst.done",      u32_t'(done), 0);
    chk("rst.allPassed", u32_t'(allPassed), 0);
    chk("rst.sel",       u32_t'(testSelect), 0);
    chk("rst.masks",     u32_t'(passMask) + u32_t'(timeoutMask), 0);
    chk("rst.failCount", u32_t'(failCount), 0);

    @(negedge clock);
    rst_n = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    chk("idle.busy",      u32_t'(busy), 0);
    chk("idle.testReset", u32_t'(testReset), 1);

    // Consecutive rows also exercise restarting from DONE
    for (int r = 0; r < 9; r++) run_check(tbl[r], $sformatf("vec%0d", r));

    // Asynchronous reset between edges during RUN of test 2
    load(tbl[0]);
    pulse_start();
    n = 0;
    while (!(u32_t'(testSelect) == 2 && !testReset) && n < 200) begin
      @(posedge clock);
      #1;
      n++;
    end
    chk("arst.reach_run2", u32_t'(n < 200), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst.testReset", u32_t'(testReset), 1);
    chk("arst.busy",      u32_t'(busy), 0);
    chk("arst.done",      u32_t'(done), 0);
    chk("arst.passMask",  u32_t'(passMask), 0);
    chk("arst.sel",       u32_t'(testSelect), 0);
    chk("arst.failCount", u32_t'(failCount), 0);
    @(negedge clock);
    rst_n = 1'b1;
    run_check(tbl[0], "arst.rerun");

    // Randomized profiles against the reference model
    for (int k = 0; k < 12; k++) begin
      for (int i = 0; i < NT; i++) v.fin[i] = 8'($urandom_range(0, 12));
      v.suc    = NT'($urandom);
      v.inject = -1;
      v        = model(v);
      run_check(v, $sformatf("rnd%0d", k));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
